// File: rtl/gp_reg_file.sv
// General-purpose register file: NREGS x WIDTH registers written from bus, sec or step
// sources with fixed priority, two combinational read ports and registered status flags.
module gp_reg_file #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 4,
    parameter int AW     = 2,
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_we,
    input  logic [AW-1:0]    bus_sel,
    input  logic [WIDTH-1:0] sec_in,
    input  logic             sec_we,
    input  logic [AW-1:0]    sec_sel,
    input  logic             step_en,
    input  logic             step_dn,
    input  logic [AW-1:0]    step_sel,
    input  logic [AW-1:0]    rd_a_sel,
    output logic [WIDTH-1:0] rd_a,
    input  logic [AW-1:0]    rd_b_sel,
    output logic [WIDTH-1:0] rd_b,
    output logic             step_wrap,
    output logic             conflict
);

    logic [WIDTH-1:0] regs     [NREGS];
    logic [WIDTH-1:0] next_val [NREGS];
    logic [NREGS-1:0] upd;
    logic             bus_ok;
    logic             sec_ok;
    logic             step_ok;
    logic             wrap_next;
    logic             conflict_next;

    // Out-of-range selects are filtered here so they neither write nor count as contention.
    always_comb begin
        bus_ok  = bus_we  && (32'(bus_sel)  < NREGS);
        sec_ok  = sec_we  && (32'(sec_sel)  < NREGS);
        step_ok = step_en && (32'(step_sel) < NREGS);

        conflict_next = (bus_ok && sec_ok  && (bus_sel == sec_sel))  ||
                        (bus_ok && step_ok && (bus_sel == step_sel)) ||
                        (sec_ok && step_ok && (sec_sel == step_sel));

        wrap_next = 1'b0;
        upd       = '0;
        for (int i = 0; i < NREGS; i++) begin
            next_val[i] = regs[i];
            if (bus_ok && (bus_sel == AW'(i))) begin
                next_val[i] = bus_in;
                upd[i]      = 1'b1;
            end else if (sec_ok && (sec_sel == AW'(i))) begin
                next_val[i] = sec_in;
                upd[i]      = 1'b1;
            end else if (step_ok && (step_sel == AW'(i))) begin
                upd[i] = 1'b1;
                if (step_dn) begin
                    next_val[i] = regs[i] - WIDTH'(1);
                    wrap_next   = (regs[i] == '0);
                end else begin
                    next_val[i] = regs[i] + WIDTH'(1);
                    wrap_next   = (regs[i] == '1);
                end
            end
        end
    end

    // With BYPASS the ports forward the value the register is about to take, or 0 under reset.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_a_sel == AW'(i)) begin
                if (BYPASS != 0) rd_a = rst ? '0 : next_val[i];
                else             rd_a = regs[i];
            end
            if (rd_b_sel == AW'(i)) begin
                if (BYPASS != 0) rd_b = rst ? '0 : next_val[i];
                else             rd_b = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            step_wrap <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (upd[i]) regs[i] <= next_val[i];
            end
            step_wrap <= wrap_next;
            conflict  <= conflict_next;
        end
    end

endmodule

// File: tb/tb_gp_reg_file.sv
// Scoreboard bench for gp_reg_file: three instances (plain, bypass, three-register) share
// stimulus; a behavioural model pushes expected reads/flags that are popped and compared.
module tb_gp_reg_file;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] bus_in, sec_in;
    logic         bus_we, sec_we, step_en, step_dn;
    logic [1:0]   bus_sel, sec_sel, step_sel, rd_a_sel, rd_b_sel;

    logic [W-1:0] rd_a_o [3];
    logic [W-1:0] rd_b_o [3];
    logic         wrap_o [3];
    logic         conf_o [3];

    gp_reg_file #(.WIDTH(16), .NREGS(4), .AW(2), .BYPASS(0)) u_plain (
        .clk(clk), .rst(rst),
        .bus_in(bus_in), .bus_we(bus_we), .bus_sel(bus_sel),
        .sec_in(sec_in), .sec_we(sec_we), .sec_sel(sec_sel),
        .step_en(step_en), .step_dn(step_dn), .step_sel(step_sel),
        .rd_a_sel(rd_a_sel), .rd_a(rd_a_o[0]), .rd_b_sel(rd_b_sel), .rd_b(rd_b_o[0]),
        .step_wrap(wrap_o[0]), .conflict(conf_o[0])
    );

    gp_reg_file #(.WIDTH(16), .NREGS(4), .AW(2), .BYPASS(1)) u_bypass (
        .clk(clk), .rst(rst),
        .bus_in(bus_in), .bus_we(bus_we), .bus_sel(bus_sel),
        .sec_in(sec_in), .sec_we(sec_we), .sec_sel(sec_sel),
        .step_en(step_en), .step_dn(step_dn), .step_sel(step_sel),
        .rd_a_sel(rd_a_sel), .rd_a(rd_a_o[1]), .rd_b_sel(rd_b_sel), .rd_b(rd_b_o[1]),
        .step_wrap(wrap_o[1]), .conflict(conf_o[1])
    );

    gp_reg_file #(.WIDTH(16), .NREGS(3), .AW(2), .BYPASS(0)) u_three (
        .clk(clk), .rst(rst),
        .bus_in(bus_in), .bus_we(bus_we), .bus_sel(bus_sel),
        .sec_in(sec_in), .sec_we(sec_we), .sec_sel(sec_sel),
        .step_en(step_en), .step_dn(step_dn), .step_sel(step_sel),
        .rd_a_sel(rd_a_sel), .rd_a(rd_a_o[2]), .rd_b_sel(rd_b_sel), .rd_b(rd_b_o[2]),
        .step_wrap(wrap_o[2]), .conflict(conf_o[2])
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         wrap;
        logic         conf;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] mreg  [3][4];
    logic [W-1:0] mnext [3][4];
    int           nr [3] = '{4, 4, 3};
    int           bp [3] = '{0, 1, 0};
    int           tests  = 0;
    int           failed = 0;

    task automatic checkOutput(input string tag, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, expv);
        end
    endtask

    function automatic logic [W-1:0] readModel(input int k, input logic [1:0] sel);
        if (int'(sel) >= nr[k]) return '0;
        if (bp[k] != 0) return rst ? '0 : mnext[k][sel];
        return mreg[k][sel];
    endfunction

    // Behavioural view: step first from the stored value, then sec, then bus overwrite.
    task automatic modelCycle(input int k, output exp_t e);
        logic         bok, sok, tok;
        logic [W-1:0] old;
        bok = bus_we  && (int'(bus_sel)  < nr[k]);
        sok = sec_we  && (int'(sec_sel)  < nr[k]);
        tok = step_en && (int'(step_sel) < nr[k]);
        for (int i = 0; i < 4; i++) mnext[k][i] = mreg[k][i];
        e.wrap = 1'b0;
        if (tok && !(bok && bus_sel == step_sel) && !(sok && sec_sel == step_sel)) begin
            old = mreg[k][step_sel];
            if (step_dn) begin
                mnext[k][step_sel] = old - 16'd1;
                e.wrap = (old == 16'h0000);
            end else begin
                mnext[k][step_sel] = old + 16'd1;
                e.wrap = (old == 16'hFFFF);
            end
        end
        if (sok && !(bok && bus_sel == sec_sel)) mnext[k][sec_sel] = sec_in;
        if (bok) mnext[k][bus_sel] = bus_in;
        e.conf = (bok && sok && bus_sel == sec_sel) || (bok && tok && bus_sel == step_sel) ||
                 (sok && tok && sec_sel == step_sel);
        if (rst) begin
            for (int i = 0; i < 4; i++) mnext[k][i] = '0;
            e.wrap = 1'b0;
            e.conf = 1'b0;
        end
        e.a = readModel(k, rd_a_sel);
        e.b = readModel(k, rd_b_sel);
    endtask

    task automatic applyStimulus(input string tag);
        exp_t e;
        exp_t cur [3];
        for (int k = 0; k < 3; k++) begin
            modelCycle(k, e);
            exp_q.push_back(e);
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            cur[k] = exp_q.pop_front();
            checkOutput($sformatf("%s/u%0d/rd_a", tag, k), rd_a_o[k], cur[k].a);
            checkOutput($sformatf("%s/u%0d/rd_b", tag, k), rd_b_o[k], cur[k].b);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s/u%0d/step_wrap", tag, k), {15'b0, wrap_o[k]}, {15'b0, cur[k].wrap});
            checkOutput($sformatf("%s/u%0d/conflict", tag, k), {15'b0, conf_o[k]}, {15'b0, cur[k].conf});
            for (int i = 0; i < 4; i++) mreg[k][i] = mnext[k][i];
        end
        @(negedge clk);
    endtask

    task automatic setIdle();
        rst      = 1'b0;
        bus_we   = 1'b0;
        sec_we   = 1'b0;
        step_en  = 1'b0;
        step_dn  = 1'b0;
        bus_sel  = 2'd0;
        sec_sel  = 2'd0;
        step_sel = 2'd0;
        bus_in   = '0;
        sec_in   = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setIdle();
        rd_a_sel = 2'd0;
        rd_b_sel = 2'd1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) mreg[k][i] = '0;
        rst = 1'b0;
        applyStimulus("reset_state");

        // Reset beats a write and a would-be conflict in the same cycle.
        setIdle(); bus_we = 1; bus_sel = 2'd1; bus_in = 16'h1234; rd_a_sel = 2'd1;
        applyStimulus("preload_r1");
        setIdle(); rst = 1; bus_we = 1; bus_sel = 2'd1; bus_in = 16'hBEEF;
        sec_we = 1; sec_sel = 2'd1; sec_in = 16'h4321;
        applyStimulus("reset_prio");
        setIdle();
        applyStimulus("after_reset");

        setIdle(); rd_a_sel = 2'd2; rd_b_sel = 2'd2;
        bus_we = 1; bus_sel = 2'd2; bus_in = 16'hAAAA;
        sec_we = 1; sec_sel = 2'd2; sec_in = 16'h5555;
        step_en = 1; step_sel = 2'd2;
        applyStimulus("prio");
        setIdle();
        applyStimulus("prio_idle");

        setIdle(); bus_we = 1; bus_sel = 2'd1; bus_in = 16'h0010;
        applyStimulus("pre_parallel");
        setIdle(); rd_a_sel = 2'd0; rd_b_sel = 2'd3;
        bus_we = 1; bus_sel = 2'd0; bus_in = 16'h0001;
        sec_we = 1; sec_sel = 2'd3; sec_in = 16'h0300;
        step_en = 1; step_sel = 2'd1;
        applyStimulus("parallel");
        setIdle();
        applyStimulus("parallel_r0_r3");
        rd_a_sel = 2'd1;
        applyStimulus("parallel_r1");

        setIdle(); rd_a_sel = 2'd2; rd_b_sel = 2'd0;
        bus_we = 1; bus_sel = 2'd2; bus_in = 16'hFFFF;
        applyStimulus("wrap_load");
        setIdle(); step_en = 1; step_sel = 2'd2;
        applyStimulus("wrap_up");
        step_dn = 1;
        applyStimulus("wrap_down");
        applyStimulus("step_down");
        setIdle();
        applyStimulus("wrap_idle");

        setIdle(); rd_a_sel = 2'd1; rd_b_sel = 2'd1;
        bus_we = 1; bus_sel = 2'd1; bus_in = 16'h0C0C;
        applyStimulus("read_timing");
        setIdle();
        applyStimulus("read_after");

        setIdle(); rd_a_sel = 2'd3; rd_b_sel = 2'd2;
        bus_we = 1; bus_sel = 2'd3; bus_in = 16'h7777;
        sec_we = 1; sec_sel = 2'd3; sec_in = 16'h8888;
        applyStimulus("out_of_range");
        setIdle();
        applyStimulus("out_of_range_idle");

        for (int n = 0; n < 60; n++) begin
            setIdle();
            rst      = ($urandom_range(0, 19) == 0);
            bus_we   = 1'($urandom_range(0, 1));
            bus_sel  = 2'($urandom);
            bus_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            sec_we   = 1'($urandom_range(0, 1));
            sec_sel  = 2'($urandom);
            sec_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            step_en  = 1'($urandom_range(0, 1));
            step_dn  = 1'($urandom_range(0, 1));
            step_sel = 2'($urandom);
            rd_a_sel = 2'($urandom);
            rd_b_sel = 2'($urandom);
            applyStimulus("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
